// File: rtl/elevator_pkg.sv
// Shared types, sizes and floor-mask helpers for the elevator sequencing core.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } state_t;

    typedef logic [NUM_FLOORS-1:0] floorMask_t;

    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    // One-hot mask of a single floor.
    function automatic floorMask_t floorOneHot(input logic [FLOOR_W-1:0] floor);
        return floorMask_t'(4'b0001) << floor;
    endfunction

    // Floors strictly above the given floor.
    function automatic floorMask_t aboveMask(input logic [FLOOR_W-1:0] floor);
        return floorMask_t'(4'b1110) << floor;
    endfunction

    // Floors strictly below the given floor.
    function automatic floorMask_t belowMask(input logic [FLOOR_W-1:0] floor);
        return ~(floorMask_t'(4'b1111) << floor);
    endfunction

endpackage

// File: rtl/interval_timer.sv
// Loadable down-counter. After a load of N, done is high during the N-th cycle
// following the load edge, so the owner acts on the edge that ends the interval.
module interval_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Count down from load_value-1; done is registered and marks the last cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            done  <= 1'b0;
        end else if (load) begin
            count <= load_value - WIDTH'(1);
            done  <= (load_value == WIDTH'(1));
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
            done  <= (count == WIDTH'(1));
        end else begin
            done  <= 1'b0;
        end
    end

endmodule

// File: rtl/elevator_controller.sv
// Four-floor elevator sequencer: request latch, collective direction policy,
// and one shared interval timer for floor-to-floor travel and door dwell.
module elevator_controller
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 50_000_000,
    parameter int DOOR_CYCLES   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0]    actualFloor,
    output logic                  upDown_Flag,
    output logic                  stopGo_Flag,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);

    state_t               state;
    state_t               nextState;
    logic [FLOOR_W-1:0]   nextFloor;
    logic [FLOOR_W-1:0]   stepFloor;
    logic                 nextUp;
    logic                 canStep;
    logic                 timerLoad;
    logic                 timerDone;
    logic [TIMER_W-1:0]   timerValue;
    floorMask_t           clr;
    floorMask_t           hereMask;
    floorMask_t           aheadReq;
    floorMask_t           behindReq;
    floorMask_t           beyondReq;

    interval_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (timerLoad),
        .load_value(timerValue),
        .done      (timerDone)
    );

    // Next-state, direction, floor step, request clear and timer control.
    always_comb begin
        nextState  = state;
        nextFloor  = actualFloor;
        nextUp     = upDown_Flag;
        clr        = '0;
        timerLoad  = 1'b0;
        timerValue = TIMER_W'(TRAVEL_CYCLES);

        hereMask  = floorOneHot(actualFloor);
        aheadReq  = pending & (upDown_Flag ? aboveMask(actualFloor) : belowMask(actualFloor));
        behindReq = pending & (upDown_Flag ? belowMask(actualFloor) : aboveMask(actualFloor));
        canStep   = upDown_Flag ? (actualFloor != TOP_FLOOR) : (actualFloor != '0);
        stepFloor = upDown_Flag ? (actualFloor + FLOOR_W'(1)) : (actualFloor - FLOOR_W'(1));
        beyondReq = pending & (upDown_Flag ? aboveMask(stepFloor) : belowMask(stepFloor));

        case (state)
            IDLE: begin
                if ((pending & hereMask) != '0) begin
                    nextState  = DOOR;
                    clr        = hereMask;
                    timerLoad  = 1'b1;
                    timerValue = TIMER_W'(DOOR_CYCLES);
                end else if (aheadReq != '0) begin
                    nextState  = MOVE;
                    timerLoad  = 1'b1;
                end else if (behindReq != '0) begin
                    // Reverse and depart on the same edge.
                    nextUp     = ~upDown_Flag;
                    nextState  = MOVE;
                    timerLoad  = 1'b1;
                end
            end
            MOVE: begin
                if (timerDone) begin
                    if (!canStep) begin
                        // Already at the end of the shaft: never wrap.
                        nextState = IDLE;
                    end else begin
                        nextFloor = stepFloor;
                        if (pending[stepFloor]) begin
                            nextState  = DOOR;
                            clr        = floorOneHot(stepFloor);
                            timerLoad  = 1'b1;
                            timerValue = TIMER_W'(DOOR_CYCLES);
                        end else if (beyondReq != '0) begin
                            timerLoad  = 1'b1;
                        end else begin
                            nextState  = IDLE;
                        end
                    end
                end
            end
            DOOR: begin
                clr = hereMask;
                if ((call_req & hereMask) != '0) begin
                    // A fresh call for this floor holds the door open longer.
                    timerLoad  = 1'b1;
                    timerValue = TIMER_W'(DOOR_CYCLES);
                end else if (timerDone) begin
                    nextState  = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Registered outputs and request latch; clear wins over a same-cycle call.
    always_ff @(posedge clk) begin
        if (reset) begin
            actualFloor <= '0;
            upDown_Flag <= 1'b1;
            stopGo_Flag <= 1'b1;
            door_open   <= 1'b0;
            pending     <= '0;
        end else begin
            actualFloor <= nextFloor;
            upDown_Flag <= nextUp;
            stopGo_Flag <= (nextState != MOVE);
            door_open   <= (nextState == DOOR);
            pending     <= (pending | call_req) & ~clr;
        end
    end

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench for elevator_controller (TRAVEL_CYCLES=4, DOOR_CYCLES=6).
// Stimulus pushes the expected output snapshots with their cycle numbers;
// the monitor pops one entry every time the observed outputs change.
module tb_elevator_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] call_req;
    logic [1:0] actualFloor;
    logic       upDown_Flag;
    logic       stopGo_Flag;
    logic       door_open;
    logic [3:0] pending;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit monEn    = 1'b0;

    typedef struct packed {
        int         cyc;
        logic [8:0] snap;
    } exp_t;

    exp_t       expQ[$];
    logic [8:0] prevSnap = '0;
    int         evtIdx   = 0;

    elevator_controller #(
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .call_req   (call_req),
        .actualFloor(actualFloor),
        .upDown_Flag(upDown_Flag),
        .stopGo_Flag(stopGo_Flag),
        .door_open  (door_open),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output change is one event, compared against the queue head.
    always @(negedge clk) begin
        logic [8:0] cur;
        exp_t       e;
        cur = {actualFloor, upDown_Flag, stopGo_Flag, door_open, pending};
        if (monEn && cur !== prevSnap) begin
            checks++;
            evtIdx++;
            if (expQ.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event_%0d cyc=%0d got snap=%b (floor,up,stop,door,pend) required no change",
                         evtIdx, cyc, cur);
            end else begin
                e = expQ.pop_front();
                if (e.cyc != cyc || e.snap !== cur) begin
                    failures++;
                    $display("FAIL event_%0d got cyc=%0d snap=%b required cyc=%0d snap=%b",
                             evtIdx, cyc, cur, e.cyc, e.snap);
                end
            end
        end
        prevSnap = cur;
    end

    task automatic pushExp(input int cy, input logic [1:0] f, input logic up,
                           input logic st, input logic dr, input logic [3:0] p);
        exp_t e;
        e.cyc  = cy;
        e.snap = {f, up, st, dr, p};
        expQ.push_back(e);
    endtask

    task automatic waitTo(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic checkVal(input string name, input logic [3:0] got, input logic [3:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, got, req);
        end
    endtask

    // From floor 0 with up=1: call for floor 0 opens the door without moving.
    task automatic scenarioHere();
        int c;
        @(negedge clk);
        c = cyc;
        pushExp(c + 1, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0001);
        pushExp(c + 2, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0000);
        pushExp(c + 8, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0000);
        call_req = 4'b0001;
        @(negedge clk);
        call_req = 4'b0000;
        waitTo(c + 10);
    endtask

    // Floor 0 to floor 3 without intermediate stops.
    task automatic scenarioUpFull();
        int c;
        @(negedge clk);
        c = cyc;
        pushExp(c + 1,  2'd0, 1'b1, 1'b1, 1'b0, 4'b1000);
        pushExp(c + 2,  2'd0, 1'b1, 1'b0, 1'b0, 4'b1000);
        pushExp(c + 6,  2'd1, 1'b1, 1'b0, 1'b0, 4'b1000);
        pushExp(c + 10, 2'd2, 1'b1, 1'b0, 1'b0, 4'b1000);
        pushExp(c + 14, 2'd3, 1'b1, 1'b1, 1'b1, 4'b0000);
        pushExp(c + 20, 2'd3, 1'b1, 1'b1, 1'b0, 4'b0000);
        call_req = 4'b1000;
        @(negedge clk);
        call_req = 4'b0000;
        waitTo(c + 22);
    endtask

    // Floor 3 (up=1) to floor 0: direction flips on the departure edge.
    task automatic scenarioDownFull();
        int c;
        @(negedge clk);
        c = cyc;
        pushExp(c + 1,  2'd3, 1'b1, 1'b1, 1'b0, 4'b0001);
        pushExp(c + 2,  2'd3, 1'b0, 1'b0, 1'b0, 4'b0001);
        pushExp(c + 6,  2'd2, 1'b0, 1'b0, 1'b0, 4'b0001);
        pushExp(c + 10, 2'd1, 1'b0, 1'b0, 1'b0, 4'b0001);
        pushExp(c + 14, 2'd0, 1'b0, 1'b1, 1'b1, 4'b0000);
        pushExp(c + 20, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000);
        call_req = 4'b0001;
        @(negedge clk);
        call_req = 4'b0000;
        waitTo(c + 22);
    endtask

    // From floor 0 (up=0) toward 3; call for floor 2 arrives en route.
    task automatic scenarioIntermediate();
        int c;
        @(negedge clk);
        c = cyc;
        pushExp(c + 1,  2'd0, 1'b0, 1'b1, 1'b0, 4'b1000);
        pushExp(c + 2,  2'd0, 1'b1, 1'b0, 1'b0, 4'b1000);
        pushExp(c + 4,  2'd0, 1'b1, 1'b0, 1'b0, 4'b1100);
        pushExp(c + 6,  2'd1, 1'b1, 1'b0, 1'b0, 4'b1100);
        pushExp(c + 10, 2'd2, 1'b1, 1'b1, 1'b1, 4'b1000);
        pushExp(c + 16, 2'd2, 1'b1, 1'b1, 1'b0, 4'b1000);
        pushExp(c + 17, 2'd2, 1'b1, 1'b0, 1'b0, 4'b1000);
        pushExp(c + 21, 2'd3, 1'b1, 1'b1, 1'b1, 4'b0000);
        pushExp(c + 27, 2'd3, 1'b1, 1'b1, 1'b0, 4'b0000);
        call_req = 4'b1000;
        @(negedge clk);
        call_req = 4'b0000;
        waitTo(c + 3);
        call_req = 4'b0100;
        @(negedge clk);
        call_req = 4'b0000;
        waitTo(c + 29);
    endtask

    // At floor 2 going up with floors 3 and 0 pending: 3 first, then reverse to 0.
    task automatic scenarioCollective();
        int c;
        @(negedge clk);
        c = cyc;
        pushExp(c + 1,  2'd0, 1'b0, 1'b1, 1'b0, 4'b0100);
        pushExp(c + 2,  2'd0, 1'b1, 1'b0, 1'b0, 4'b0100);
        pushExp(c + 6,  2'd1, 1'b1, 1'b0, 1'b0, 4'b0100);
        pushExp(c + 10, 2'd2, 1'b1, 1'b1, 1'b1, 4'b0000);
        pushExp(c + 12, 2'd2, 1'b1, 1'b1, 1'b1, 4'b1001);
        pushExp(c + 16, 2'd2, 1'b1, 1'b1, 1'b0, 4'b1001);
        pushExp(c + 17, 2'd2, 1'b1, 1'b0, 1'b0, 4'b1001);
        pushExp(c + 21, 2'd3, 1'b1, 1'b1, 1'b1, 4'b0001);
        pushExp(c + 27, 2'd3, 1'b1, 1'b1, 1'b0, 4'b0001);
        pushExp(c + 28, 2'd3, 1'b0, 1'b0, 1'b0, 4'b0001);
        pushExp(c + 32, 2'd2, 1'b0, 1'b0, 1'b0, 4'b0001);
        pushExp(c + 36, 2'd1, 1'b0, 1'b0, 1'b0, 4'b0001);
        pushExp(c + 40, 2'd0, 1'b0, 1'b1, 1'b1, 4'b0000);
        pushExp(c + 46, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000);
        call_req = 4'b0100;
        @(negedge clk);
        call_req = 4'b0000;
        waitTo(c + 11);
        call_req = 4'b1001;
        @(negedge clk);
        call_req = 4'b0000;
        waitTo(c + 48);
    endtask

    // Door at floor 1 re-triggered in its 4th cycle: stays open 6 more cycles.
    task automatic scenarioDoorRestart();
        int c;
        @(negedge clk);
        c = cyc;
        pushExp(c + 1,  2'd0, 1'b0, 1'b1, 1'b0, 4'b0010);
        pushExp(c + 2,  2'd0, 1'b1, 1'b0, 1'b0, 4'b0010);
        pushExp(c + 6,  2'd1, 1'b1, 1'b1, 1'b1, 4'b0000);
        pushExp(c + 16, 2'd1, 1'b1, 1'b1, 1'b0, 4'b0000);
        call_req = 4'b0010;
        @(negedge clk);
        call_req = 4'b0000;
        waitTo(c + 9);
        call_req = 4'b0010;
        @(negedge clk);
        call_req = 4'b0000;
        checkVal("door_restart_pending", pending, 4'b0000);
        waitTo(c + 18);
    endtask

    // Reset pulsed while travelling from floor 1 to floor 2.
    task automatic scenarioResetMidMove();
        int c;
        @(negedge clk);
        c = cyc;
        pushExp(c + 1, 2'd1, 1'b1, 1'b1, 1'b0, 4'b1000);
        pushExp(c + 2, 2'd1, 1'b1, 1'b0, 1'b0, 4'b1000);
        pushExp(c + 4, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0000);
        call_req = 4'b1000;
        @(negedge clk);
        call_req = 4'b0000;
        waitTo(c + 3);
        reset = 1'b1;
        @(negedge clk);
        checkVal("rst_move_floor",  {2'b00, actualFloor}, 4'd0);
        checkVal("rst_move_pend",   pending,              4'b0000);
        checkVal("rst_move_stop",   {3'b000, stopGo_Flag}, 4'd1);
        checkVal("rst_move_up",     {3'b000, upDown_Flag}, 4'd1);
        checkVal("rst_move_door",   {3'b000, door_open},   4'd0);
        reset = 1'b0;
        waitTo(c + 16);
    endtask

    initial begin
        reset    = 1'b1;
        call_req = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("reset_floor", {2'b00, actualFloor}, 4'd0);
        checkVal("reset_up",    {3'b000, upDown_Flag}, 4'd1);
        checkVal("reset_stop",  {3'b000, stopGo_Flag}, 4'd1);
        checkVal("reset_door",  {3'b000, door_open},   4'd0);
        checkVal("reset_pend",  pending,               4'b0000);
        reset = 1'b0;
        monEn = 1'b1;

        scenarioHere();
        scenarioUpFull();
        scenarioDownFull();
        scenarioIntermediate();
        scenarioDownFull();
        scenarioCollective();
        scenarioDoorRestart();
        scenarioResetMidMove();

        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL missing_events got=%0d_left required=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/elevator_controller.md
# elevator_controller

Four-floor elevator sequencing core: latches floor call requests, drives a one-floor-at-a-time travel timer and a door-open timer, and chooses the travel direction with a collective (keep-direction) policy. It sits directly upstream of the display controller and produces the `actualFloor`, `upDown_Flag` and `stopGo_Flag` signals that the display controller renders on the 4-digit seven-segment display. It also exports door and pending-request status for LEDs.

## Interface

Parameters:
- `TRAVEL_CYCLES`, default 50_000_000: clock cycles spent moving between adjacent floors. Must be ≥1.
- `DOOR_CYCLES`, default 100_000_000: clock cycles the door stays open. Must be ≥1.

Ports:
- `clk`  in  1  system clock. One clock domain; every register uses this clock.
- `reset`  in  1  synchronous, active-high reset.
- `call_req`  in  4  floor call buttons, already debounced and synchronised. Bit i is floor i. Level or pulse; a bit is sampled on every edge.
- `actualFloor`  out  2  current floor, 0–3.
- `upDown_Flag`  out  1  1 = up, 0 = down. Holds the last direction while stopped.
- `stopGo_Flag`  out  1  1 = stopped (IDLE or DOOR), 0 = moving.
- `door_open`  out  1  high only in DOOR.
- `pending`  out  4  latched, not-yet-served requests.

## Operation

States: IDLE, MOVE, DOOR. All outputs are registered.

Request latch:
- `pending <= (pending | call_req) & ~clr`.
- `clr` is the one-hot bit of the floor being served: on entry to DOOR, and on every cycle spent in DOOR for `actualFloor`.

IDLE: evaluated on registered `pending`, in this priority order.
1. `pending[actualFloor]` → DOOR.
2. Requests exist in the current direction → MOVE in that direction.
3. Requests exist in the opposite direction → flip `upDown_Flag`, then MOVE.
4. Otherwise stay in IDLE.

MOVE:
- The timer counts TRAVEL_CYCLES cycles. On the terminal count, `actualFloor` moves ±1.
- After the step, if `pending[new floor]` is set → DOOR.
- Else, if requests exist beyond the new floor in the same direction → stay in MOVE and restart the timer.
- Else → IDLE (defensive path).
- The floor saturates at 0 and 3 and never wraps.

DOOR:
- `door_open=1` and the timer counts DOOR_CYCLES cycles, then → IDLE.
- A `call_req` for `actualFloor` during DOOR restarts the door timer; its pending bit stays cleared.

Width rules:
- Timer width is `$clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)+1)`.
- Floor arithmetic is 2-bit, guarded by the saturation checks above.

## Timing

- Reset values: state=IDLE, `actualFloor`=0, `upDown_Flag`=1, `stopGo_Flag`=1, `door_open`=0, `pending`=0, timer=0. Reset wins over every other event, including mid-MOVE and mid-DOOR.
- `call_req` asserted at edge n → `pending` bit visible after edge n+1.
- From IDLE, the decision takes one cycle: the new state, `stopGo_Flag` and `door_open` update on the edge after `pending` becomes visible.
- `stopGo_Flag` falls on the MOVE entry edge and rises on the DOOR or IDLE entry edge.
- The floor changes on the edge that ends the TRAVEL_CYCLES-th MOVE cycle. `door_open` rises on that same edge if the new floor is served.
- DOOR lasts exactly DOOR_CYCLES cycles, measured from the last restart.
- A call for the current floor arriving in the same cycle as the clear: the bit stays 0 (clear wins), and in DOOR the timer restarts.
- A call for a passed floor stays pending and is served after the direction reverses.

## Structure

- Package `elevator_pkg`: state enum `{IDLE, MOVE, DOOR}`, `NUM_FLOORS=4`, `FLOOR_W=2`.
- Sub-module `interval_timer`: a loadable down-counter with `load`, `load_value` and a registered `done` pulse. A single instance is shared by MOVE and DOOR, since only one of them is active at a time.
- The request latch and direction logic live in the top module.

## Test plan

Bench parameters: TRAVEL_CYCLES=4, DOOR_CYCLES=6.

- Floor 0, single cycle of `call_req=4'b1000` at edge c → `pending=1000` at c+1; MOVE up at c+2 with `stopGo_Flag=0`; `actualFloor` 1/2/3 at c+6/c+10/c+14; `door_open` high c+14..c+19; IDLE at c+20 with `pending=0`.
- Floor 0, `call_req=4'b0001` → DOOR two edges later with no movement; `actualFloor` stays 0; door open for 6 cycles.
- Moving up from 0 toward 3, `call_req=4'b0100` pulsed before floor 2 is reached → stops at 2 with DOOR, then resumes up to 3. `upDown_Flag` stays 1 throughout.
- At floor 2 going up, pending floors 3 and 0 → serves 3 first, then flips `upDown_Flag` to 0 and serves 0.
- In DOOR at floor 1, `call_req=4'b0010` pulsed at door cycle 4 → door stays open 6 more cycles; `pending[1]` stays 0.
- `reset` pulsed mid-MOVE between floors 1 and 2 → next edge: `actualFloor=0`, `pending=0`, `stopGo_Flag=1`, `upDown_Flag=1`, `door_open=0`.
